// File: rtl/inst_fetch.sv
// inst_fetch
//   Fetch stage feeding the instruction decoder. Owns the program counter,
//   addresses a combinational instruction ROM, and registers the returned word
//   together with its PC into a one-entry fetch buffer. The buffer is handed to
//   decode over a valid/ready handshake. Execute can redirect the PC at any time;
//   a redirect squashes the buffered instruction.
//
// Ports
//   clk            in   rising-edge clock
//   rst_n          in   asynchronous active-low reset
//   enable         in   fetch permitted (low pauses new captures)
//   romAddr        out  ROM address, always the PC register
//   romInst        in   ROM data, combinational from romAddr
//   redirectValid  in   load redirectPc into the PC this cycle
//   redirectPc     in   redirect target
//   instValid      out  fetch buffer holds a valid instruction
//   instOut        out  buffered instruction
//   instPc         out  address of the buffered instruction
//   instReady      in   decode consumes the buffer when instValid && instReady
//   fetchCount     out  instructions captured since reset, saturating

module inst_fetch #(
  parameter int unsigned       ADDR_W   = 8,
  parameter int unsigned       INST_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  output logic [ADDR_W-1:0] romAddr,
  input  logic [INST_W-1:0] romInst,
  input  logic              redirectValid,
  input  logic [ADDR_W-1:0] redirectPc,
  output logic              instValid,
  output logic [INST_W-1:0] instOut,
  output logic [ADDR_W-1:0] instPc,
  input  logic              instReady,
  output logic [15:0]       fetchCount
);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_fetch_en;
  logic                w_accept;

  logic [ADDR_W-1:0]   r_pc;
  logic                r_valid;
  logic [INST_W-1:0]   r_inst;
  logic [ADDR_W-1:0]   r_inst_pc;
  logic [15:0]         r_count;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_BOOT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; redirects never influence the state
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_BOOT:  w_state_nxt = enable ? ST_RUN : ST_PAUSE;
      ST_RUN:   w_state_nxt = enable ? ST_RUN : ST_PAUSE;
      ST_PAUSE: w_state_nxt = enable ? ST_RUN : ST_PAUSE;
      default:  w_state_nxt = ST_BOOT;
    endcase
  end

  // State-derived outputs
  always_comb begin
    w_fetch_en = 1'b0;
    if (r_state == ST_RUN) begin
      w_fetch_en = 1'b1;
    end
  end

  // Capture needs a free (or freeing) buffer and loses to any redirect
  assign w_accept = w_fetch_en && enable && !redirectValid &&
                    (!r_valid || instReady);

  // PC and fetch buffer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc      <= RESET_PC;
      r_valid   <= 1'b0;
      r_inst    <= '0;
      r_inst_pc <= '0;
    end else if (redirectValid) begin
      // Squash even if decode is consuming the buffer this very cycle
      r_pc    <= redirectPc;
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_inst    <= romInst;
      r_inst_pc <= r_pc;
      r_valid   <= 1'b1;
      r_pc      <= r_pc + ADDR_W'(1);
    end else if (r_valid && instReady) begin
      r_valid <= 1'b0;
    end
  end

  // Saturating capture counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (w_accept && (r_count != '1)) begin
      r_count <= r_count + 16'd1;
    end
  end

  assign romAddr    = r_pc;
  assign instValid  = r_valid;
  assign instOut    = r_inst;
  assign instPc     = r_inst_pc;
  assign fetchCount = r_count;

endmodule
